// File: rtl/amm_master_pkg.sv
//------------------------------------------------------------------------------
// Module      : amm_master_pkg
// Description : Shared types and helpers for the Avalon-MM burst master.
//               - state_t   : engine state encoding
//               - max_burst : largest legal burst for a given burstcount width
//               - BE_W      : byteenable width for the default 64-bit datapath
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package amm_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_REQ   = 2'd2,
    ST_RD_WAIT  = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_W = 64;
  localparam int BE_W           = DEFAULT_DATA_W / 8;

  // Avalon burstcount of width W encodes 1..2^(W-1); the top value still fits
  // in W bits, so counters of the same width never wrap on a legal burst.
  function automatic int unsigned max_burst(input int unsigned burst_w);
    return 32'd1 << (burst_w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/amm_watchdog.sv
//------------------------------------------------------------------------------
// Module      : amm_watchdog
// Description : Stall watchdog. Counts consecutive active cycles without
//               progress and flags expiry on the TIMEOUT-th such cycle.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               active        - engine is busy (non-IDLE)
//               progress      - a beat, grant or read beat happened this cycle
//               expired       - combinational: force the engine back to IDLE
//                               at the coming edge
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module amm_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic progress,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of stalled cycles already seen, so the current
  // stalled cycle is number cnt+1; expire when that reaches TIMEOUT.
  assign expired = active && !progress && (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || !active || progress || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/amm_burst_master.sv
//------------------------------------------------------------------------------
// Module      : amm_burst_master
// Description : Avalon-MM burst master. Takes one command at a time (read or
//               write, start address, beat count) and issues a single burst.
//               Write beats stream in on wr_* (valid/ready); read beats come
//               back on rd_* (valid only, no backpressure).
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               cmd_valid/cmd_ready       - command handshake (ready in IDLE)
//               cmd_write/addr/words      - direction, start address, beats
//               cmd_last_be               - byteenable for final write beat
//               wr_data/wr_valid/wr_ready - write beat stream
//               rd_data/rd_valid          - returned read beats
//               done, err                 - one-cycle completion / error pulses
//               amm_*                     - Avalon-MM master interface
// Options     : AMM_TIMEOUT_EN - adds a stall watchdog (limit TIMEOUT cycles)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module amm_burst_master
  import amm_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 11,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  // command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [BURST_W-1:0]    cmd_words,
  input  logic [DATA_W/8-1:0]   cmd_last_be,
  // write stream
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  // read stream
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  // status
  output logic                  done,
  output logic                  err,
  // Avalon-MM master
  output logic [ADDR_W-1:0]     amm_address,
  output logic                  amm_read,
  output logic                  amm_write,
  output logic [DATA_W-1:0]     amm_writedata,
  output logic [DATA_W/8-1:0]   amm_byteenable,
  output logic [BURST_W-1:0]    amm_burstcount,
  input  logic                  amm_readdatavalid,
  input  logic [DATA_W-1:0]     amm_readdata,
  input  logic                  amm_waitrequest
);

  localparam logic [BURST_W-1:0] MAX_BURST = BURST_W'(max_burst(BURST_W));
  localparam logic [BURST_W-1:0] ONE       = BURST_W'(1);

  state_t               state;
  state_t               state_nxt;
  logic [BURST_W-1:0]   cnt;
  logic [DATA_W/8-1:0]  last_be_r;
  logic                 write_r;

  logic                 len_ok;
  logic                 accept;
  logic                 wr_xfer;
  logic                 rd_grant;
  logic                 in_read;
  logic                 rd_beat;
  logic                 stray_rdv;
  logic                 last_beat;
  logic                 final_wr;
  logic                 final_rd;
  logic                 wd_expire;

  //--------------------------------------------------------------------------
  // Event decode
  //--------------------------------------------------------------------------
  assign len_ok    = (cmd_words != '0) && (cmd_words <= MAX_BURST);
  assign accept    = cmd_valid && cmd_ready;
  assign wr_xfer   = amm_write && !amm_waitrequest;
  assign rd_grant  = amm_read && !amm_waitrequest;
  assign in_read   = (state == ST_RD_REQ) || (state == ST_RD_WAIT);
  assign rd_beat   = amm_readdatavalid && in_read;
  // Read data with no read outstanding (e.g. left over from before a reset)
  // is discarded and only flagged.
  assign stray_rdv = amm_readdatavalid && !in_read;
  assign last_beat = (cnt == amm_burstcount - ONE);
  assign final_wr  = wr_xfer && last_beat;
  assign final_rd  = rd_beat && last_beat;

  assign amm_writedata = wr_data;

  //--------------------------------------------------------------------------
  // Optional stall watchdog
  //--------------------------------------------------------------------------
`ifdef AMM_TIMEOUT_EN
  logic wd_progress;
  assign wd_progress = wr_xfer || rd_grant || rd_beat;

  amm_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .active   (state != ST_IDLE),
    .progress (wd_progress),
    .expired  (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept && len_ok) begin
          state_nxt = cmd_write ? ST_WR_BURST : ST_RD_REQ;
        end
      end
      ST_WR_BURST: begin
        if (final_wr) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        // Data may in principle return before the grant is seen; finishing
        // the count here keeps the engine from waiting on beats already gone.
        if (final_rd) begin
          state_nxt = ST_IDLE;
        end else if (rd_grant) begin
          state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (final_rd) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (wd_expire) begin
      state_nxt = ST_IDLE;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    cmd_ready      = 1'b0;
    amm_read       = 1'b0;
    amm_write      = 1'b0;
    wr_ready       = 1'b0;
    amm_byteenable = '0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
      end
      ST_WR_BURST: begin
        amm_write      = wr_valid;
        wr_ready       = !amm_waitrequest;
        amm_byteenable = (write_r && last_beat) ? last_be_r : '1;
      end
      ST_RD_REQ: begin
        amm_read       = 1'b1;
        amm_byteenable = '1;
      end
      default: ;
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath: command registers, beat counter, read return, status pulses
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      amm_address    <= '0;
      amm_burstcount <= '0;
      last_be_r      <= '0;
      write_r        <= 1'b0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= rd_beat;
      if (rd_beat) begin
        rd_data <= amm_readdata;
      end

      if (accept) begin
        if (len_ok) begin
          cnt            <= '0;
          amm_address    <= cmd_addr;
          amm_burstcount <= cmd_words;
          last_be_r      <= cmd_last_be;
          write_r        <= cmd_write;
        end else begin
          done <= 1'b1;
          err  <= 1'b1;
        end
      end else if (wr_xfer || rd_beat) begin
        cnt <= cnt + ONE;
      end

      // Registered so done lines up with the rd_valid of the final read beat.
      if (final_wr || final_rd) begin
        done <= 1'b1;
      end
      if (stray_rdv) begin
        err <= 1'b1;
      end
      if (wd_expire) begin
        done <= 1'b1;
        err  <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_amm_burst_master.sv
//------------------------------------------------------------------------------
// Module      : tb_amm_burst_master
// Description : Directed self-checking bench for amm_burst_master.
//               The watchdog scenario is included when AMM_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_amm_burst_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 11;
  localparam int BE_W    = DATA_W / 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_write = 1'b0;
  logic [ADDR_W-1:0]   cmd_addr = '0;
  logic [BURST_W-1:0]  cmd_words = '0;
  logic [BE_W-1:0]     cmd_last_be = '0;
  logic [DATA_W-1:0]   wr_data = '0;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                done;
  logic                err;
  logic [ADDR_W-1:0]   amm_address;
  logic                amm_read;
  logic                amm_write;
  logic [DATA_W-1:0]   amm_writedata;
  logic [BE_W-1:0]     amm_byteenable;
  logic [BURST_W-1:0]  amm_burstcount;
  logic                amm_readdatavalid = 1'b0;
  logic [DATA_W-1:0]   amm_readdata = '0;
  logic                amm_waitrequest = 1'b0;

  int checks = 0;
  int passes = 0;

  amm_burst_master #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .BURST_W (BURST_W),
    .TIMEOUT (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_addr          (cmd_addr),
    .cmd_words         (cmd_words),
    .cmd_last_be       (cmd_last_be),
    .wr_data           (wr_data),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .done              (done),
    .err               (err),
    .amm_address       (amm_address),
    .amm_read          (amm_read),
    .amm_write         (amm_write),
    .amm_writedata     (amm_writedata),
    .amm_byteenable    (amm_byteenable),
    .amm_burstcount    (amm_burstcount),
    .amm_readdatavalid (amm_readdatavalid),
    .amm_readdata      (amm_readdata),
    .amm_waitrequest   (amm_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    int pulses;
    int err_cnt;
    int rv_cnt;
    int dn_cnt;

    //------------------------------------------------------------ reset
    rst = 1'b1;
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_amm_read", amm_read, 0);
    chk("rst_amm_write", amm_write, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_address", amm_address, 0);
    chk("rst_burstcount", amm_burstcount, 0);
    chk("rst_byteenable", amm_byteenable, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;

    //------------------------------------------------------------ write 4 @0x100
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100;
    cmd_words = 11'd4; cmd_last_be = 8'h0F;
    #1;
    chk("w4_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    wr_valid  = 1'b1;
    amm_waitrequest = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wr_data = 64'h1111_0000 + 64'(b);
      #1;
      chk("w4_write", amm_write, 1);
      chk("w4_wr_ready", wr_ready, 1);
      chk("w4_byteenable", amm_byteenable, (b == 3) ? 64'h0F : 64'hFF);
      chk("w4_burstcount", amm_burstcount, 4);
      chk("w4_address", amm_address, 64'h100);
      chk("w4_writedata", amm_writedata, 64'h1111_0000 + 64'(b));
      chk("w4_done_early", done, 0);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("w4_done", done, 1);
    chk("w4_err", err, 0);
    chk("w4_write_off", amm_write, 0);
    chk("w4_cmd_ready_end", cmd_ready, 1);
    tick();
    chk("w4_done_pulse", done, 0);

    //------------------------------------------------------------ write 8 with stalls
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h480;
    cmd_words = 11'd8; cmd_last_be = 8'h3C;
    tick();
    cmd_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 14; c++) begin
      amm_waitrequest = (c == 1) || (c == 3);
      wr_valid = (c < 12) && !(c == 7 || c == 8);
      wr_data  = 64'hB000 + 64'(k);
      #1;
      chk("w8_done_timing", done, (c == 12) ? 1 : 0);
      if (c < 12) begin
        chk("w8_write", amm_write, wr_valid);
        chk("w8_wr_ready", wr_ready, !amm_waitrequest);
        chk("w8_address", amm_address, 64'h480);
        chk("w8_burstcount", amm_burstcount, 8);
      end
      if (amm_write && !amm_waitrequest) begin
        chk("w8_writedata", amm_writedata, 64'hB000 + 64'(k));
        chk("w8_byteenable", amm_byteenable, (k == 7) ? 64'h3C : 64'hFF);
        k++;
      end
      tick();
    end
    chk("w8_transfers", k, 8);
    amm_waitrequest = 1'b0;

    //------------------------------------------------------------ read 16 @0x2000
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h2000; cmd_words = 11'd16;
    #1;
    chk("r16_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      amm_waitrequest = (c < 3);
      #1;
      chk("r16_read", amm_read, 1);
      chk("r16_address", amm_address, 64'h2000);
      chk("r16_burstcount", amm_burstcount, 16);
      chk("r16_byteenable", amm_byteenable, 64'hFF);
      chk("r16_cmd_ready_busy", cmd_ready, 0);
      tick();
    end
    amm_waitrequest = 1'b0;
    #1;
    chk("r16_read_off", amm_read, 0);
    pulses = 0;
    for (int j = 0; j < 32; j++) begin
      amm_readdatavalid = (j % 2 == 0);
      amm_readdata = 64'hC0DE_0000 + 64'(j / 2);
      tick();
      chk("r16_rd_valid", rd_valid, (j % 2 == 0) ? 1 : 0);
      if (rd_valid) pulses++;
      if (j % 2 == 0) chk("r16_rd_data", rd_data, 64'hC0DE_0000 + 64'(j / 2));
      chk("r16_done", done, (j == 30) ? 1 : 0);
      chk("r16_cmd_ready", cmd_ready, (j >= 30) ? 1 : 0);
      chk("r16_err", err, 0);
    end
    amm_readdatavalid = 1'b0;
    chk("r16_pulses", pulses, 16);

    //------------------------------------------------------------ illegal lengths
    wr_valid  = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_words = 11'd0;
    #1;
    chk("len0_write", amm_write, 0);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("len0_done", done, 1);
    chk("len0_err", err, 1);
    chk("len0_write_after", amm_write, 0);
    chk("len0_cmd_ready", cmd_ready, 1);
    tick();
    chk("len0_done_pulse", done, 0);
    chk("len0_err_pulse", err, 0);
    wr_valid  = 1'b0;

    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_words = 11'd1025;
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("len1025_read", amm_read, 0);
    chk("len1025_done", done, 1);
    chk("len1025_err", err, 1);
    chk("len1025_cmd_ready", cmd_ready, 1);
    tick();
    chk("len1025_done_pulse", done, 0);
    chk("len1025_read_after", amm_read, 0);

    //------------------------------------------------------------ reset mid-read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3000; cmd_words = 11'd8;
    tick();
    cmd_valid = 1'b0;
    tick();                           // granted immediately
    for (int j = 0; j < 3; j++) begin
      amm_readdatavalid = 1'b1;
      amm_readdata = 64'hD000 + 64'(j);
      tick();
      chk("mid_rd_valid", rd_valid, 1);
      chk("mid_rd_data", rd_data, 64'hD000 + 64'(j));
    end
    amm_readdatavalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_read", amm_read, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    err_cnt = 0; rv_cnt = 0; dn_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      amm_readdatavalid = (i < 5);
      amm_readdata = 64'hDEAD;
      tick();
      chk("stale_err", err, (i < 5) ? 1 : 0);
      err_cnt += int'(err);
      rv_cnt  += int'(rd_valid);
      dn_cnt  += int'(done);
    end
    amm_readdatavalid = 1'b0;
    chk("stale_err_count", err_cnt, 5);
    chk("stale_rd_valid_count", rv_cnt, 0);
    chk("stale_done_count", dn_cnt, 0);

`ifdef AMM_TIMEOUT_EN
    //------------------------------------------------------------ watchdog
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_words = 11'd4;
    tick();
    cmd_valid = 1'b0;
    tick();                           // granted immediately
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("wd_done", done, (i == 16) ? 1 : 0);
      chk("wd_err", err, (i == 16) ? 1 : 0);
      chk("wd_read", amm_read, 0);
    end
    chk("wd_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_words = 11'd1;
    cmd_last_be = 8'h01; wr_valid = 1'b1; wr_data = 64'h77;
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("wd_next_write", amm_write, 1);
    chk("wd_next_be", amm_byteenable, 64'h01);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("wd_next_done", done, 1);
    chk("wd_next_err", err, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
